// File: rtl/ycbcr_skin_bin_if.sv
// Video stream bundle for ycbcr_skin_bin: pre-frame input sync/pixel and
// post-frame output sync/pixel/mask, aligned to each other.
interface ycbcr_skin_bin_if;
    logic        pre_frame_vsync;
    logic        pre_frame_hsync;
    logic        pre_frame_de;
    logic [15:0] pix_in;
    logic        post_frame_vsync;
    logic        post_frame_hsync;
    logic        post_frame_de;
    logic [15:0] pix_out;
    logic        bin_out;

    modport master (
        output pre_frame_vsync, pre_frame_hsync, pre_frame_de, pix_in,
        input  post_frame_vsync, post_frame_hsync, post_frame_de, pix_out, bin_out
    );

    modport slave (
        input  pre_frame_vsync, pre_frame_hsync, pre_frame_de, pix_in,
        output post_frame_vsync, post_frame_hsync, post_frame_de, pix_out, bin_out
    );
endinterface

// File: rtl/ycbcr_skin_bin.sv
// RGB565 -> YCbCr skin-tone binariser, 4-stage pipeline, frame-synchronous config.
// Optional foreground pixel counter enabled by defining YCBCR_FG_COUNT_EN.
module ycbcr_skin_bin #(
    parameter logic [7:0]  CR_LO_DEF = 8'd135,
    parameter logic [7:0]  CR_HI_DEF = 8'd160,
    parameter logic [7:0]  CB_LO_DEF = 8'd115,
    parameter logic [7:0]  CB_HI_DEF = 8'd140,
    parameter int unsigned CNT_W     = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    ycbcr_skin_bin_if.slave  vid,
    input  logic             cfg_wr,
    input  logic [7:0]       cfg_cr_lo,
    input  logic [7:0]       cfg_cr_hi,
    input  logic [7:0]       cfg_cb_lo,
    input  logic [7:0]       cfg_cb_hi,
    input  logic [1:0]       cfg_mode,
    output logic             cfg_pending,
    output logic [CNT_W-1:0] fg_count,
    output logic             fg_count_vld
);
    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_MASK = 2'd1;
    localparam logic [1:0] MODE_GRAY = 2'd2;
    localparam logic [1:0] MODE_GATE = 2'd3;

    logic [15:0] w_r16, w_g16, w_b16;
    logic [7:0]  w_r8, w_g8, w_b8;
    logic [15:0] r_r77, r_g150, r_b29, r_r43, r_g85, r_b128, r_r128, r_g107, r_b21;
    logic [15:0] r_y0, r_cb0, r_cr0;
    logic [7:0]  r_y, r_cb, r_cr;
    logic [15:0] r_pix_d1, r_pix_d2, r_pix_d3;
    logic [3:0]  r_vs_d, r_hs_d, r_de_d;
    logic [15:0] r_pix_out;
    logic        r_bin_out;
    logic        w_bin;
    logic [15:0] w_pix_next;

    logic [7:0]  r_act_cr_lo, r_act_cr_hi, r_act_cb_lo, r_act_cb_hi;
    logic [7:0]  r_pnd_cr_lo, r_pnd_cr_hi, r_pnd_cb_lo, r_pnd_cb_hi;
    logic [1:0]  r_act_mode, r_pnd_mode;
    logic        r_pending, r_vs_prev, w_vs_rise;

    assign w_r8  = {vid.pix_in[15:11], vid.pix_in[15:13]};
    assign w_g8  = {vid.pix_in[10:5],  vid.pix_in[10:9]};
    assign w_b8  = {vid.pix_in[4:0],   vid.pix_in[4:2]};
    assign w_r16 = {8'd0, w_r8};
    assign w_g16 = {8'd0, w_g8};
    assign w_b16 = {8'd0, w_b8};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r77 <= '0; r_g150 <= '0; r_b29  <= '0;
            r_r43 <= '0; r_g85  <= '0; r_b128 <= '0;
            r_r128 <= '0; r_g107 <= '0; r_b21 <= '0;
            r_y0 <= '0; r_cb0 <= '0; r_cr0 <= '0;
            r_y  <= '0; r_cb  <= '0; r_cr  <= '0;
            r_pix_d1 <= '0; r_pix_d2 <= '0; r_pix_d3 <= '0;
            r_vs_d <= '0; r_hs_d <= '0; r_de_d <= '0;
            r_pix_out <= '0; r_bin_out <= 1'b0;
        end else begin
            r_r77  <= w_r16 * 16'd77;
            r_g150 <= w_g16 * 16'd150;
            r_b29  <= w_b16 * 16'd29;
            r_r43  <= w_r16 * 16'd43;
            r_g85  <= w_g16 * 16'd85;
            r_b128 <= {1'b0, w_b8, 7'd0};
            r_r128 <= {1'b0, w_r8, 7'd0};
            r_g107 <= w_g16 * 16'd107;
            r_b21  <= w_b16 * 16'd21;
            // 16-bit wraparound is intended; the +32768 offset keeps chroma centred
            r_y0  <= r_r77 + r_g150 + r_b29;
            r_cb0 <= r_b128 - r_r43 - r_g85 + 16'h8000;
            r_cr0 <= r_r128 - r_g107 - r_b21 + 16'h8000;
            r_y   <= r_y0[15:8];
            r_cb  <= r_cb0[15:8];
            r_cr  <= r_cr0[15:8];
            r_pix_d1 <= vid.pix_in;
            r_pix_d2 <= r_pix_d1;
            r_pix_d3 <= r_pix_d2;
            r_vs_d <= {r_vs_d[2:0], vid.pre_frame_vsync};
            r_hs_d <= {r_hs_d[2:0], vid.pre_frame_hsync};
            r_de_d <= {r_de_d[2:0], vid.pre_frame_de};
            r_pix_out <= w_pix_next;
            r_bin_out <= w_bin;
        end
    end

    assign w_bin = (r_cr > r_act_cr_lo) && (r_cr < r_act_cr_hi) &&
                   (r_cb > r_act_cb_lo) && (r_cb < r_act_cb_hi);

    always_comb begin
        w_pix_next = '0;
        case (r_act_mode)
            MODE_PASS: w_pix_next = r_pix_d3;
            MODE_MASK: w_pix_next = {16{w_bin}};
            MODE_GRAY: w_pix_next = {r_y[7:3], r_y[7:2], r_y[7:3]};
            MODE_GATE: w_pix_next = w_bin ? r_pix_d3 : '0;
            default:   w_pix_next = '0;
        endcase
    end

    assign w_vs_rise = vid.pre_frame_vsync & ~r_vs_prev;

    // A write landing on the vsync-rise cycle bypasses pending and applies at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev   <= 1'b0;
            r_pending   <= 1'b0;
            r_act_cr_lo <= CR_LO_DEF; r_act_cr_hi <= CR_HI_DEF;
            r_act_cb_lo <= CB_LO_DEF; r_act_cb_hi <= CB_HI_DEF;
            r_pnd_cr_lo <= CR_LO_DEF; r_pnd_cr_hi <= CR_HI_DEF;
            r_pnd_cb_lo <= CB_LO_DEF; r_pnd_cb_hi <= CB_HI_DEF;
            r_act_mode  <= MODE_PASS; r_pnd_mode  <= MODE_PASS;
        end else begin
            r_vs_prev <= vid.pre_frame_vsync;
            if (w_vs_rise && cfg_wr) begin
                r_act_cr_lo <= cfg_cr_lo; r_act_cr_hi <= cfg_cr_hi;
                r_act_cb_lo <= cfg_cb_lo; r_act_cb_hi <= cfg_cb_hi;
                r_act_mode  <= cfg_mode;
                r_pnd_cr_lo <= cfg_cr_lo; r_pnd_cr_hi <= cfg_cr_hi;
                r_pnd_cb_lo <= cfg_cb_lo; r_pnd_cb_hi <= cfg_cb_hi;
                r_pnd_mode  <= cfg_mode;
                r_pending   <= 1'b0;
            end else if (w_vs_rise && r_pending) begin
                r_act_cr_lo <= r_pnd_cr_lo; r_act_cr_hi <= r_pnd_cr_hi;
                r_act_cb_lo <= r_pnd_cb_lo; r_act_cb_hi <= r_pnd_cb_hi;
                r_act_mode  <= r_pnd_mode;
                r_pending   <= 1'b0;
            end else if (cfg_wr) begin
                r_pnd_cr_lo <= cfg_cr_lo; r_pnd_cr_hi <= cfg_cr_hi;
                r_pnd_cb_lo <= cfg_cb_lo; r_pnd_cb_hi <= cfg_cb_hi;
                r_pnd_mode  <= cfg_mode;
                r_pending   <= 1'b1;
            end
        end
    end

    assign cfg_pending          = r_pending;
    assign vid.post_frame_vsync = r_vs_d[3];
    assign vid.post_frame_hsync = r_hs_d[3];
    assign vid.post_frame_de    = r_de_d[3];
    assign vid.pix_out          = r_pix_out;
    assign vid.bin_out          = r_bin_out;

`ifdef YCBCR_FG_COUNT_EN
    logic [CNT_W-1:0] r_acc, r_fg_count;
    logic             r_fg_vld, r_post_vs_prev, r_armed;
    logic             w_hit, w_post_fall;

    assign w_hit       = r_bin_out & r_de_d[3];
    assign w_post_fall = r_post_vs_prev & ~r_vs_d[3];

    // First vsync fall after reset only arms; a partial frame is never reported
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc          <= '0;
            r_fg_count     <= '0;
            r_fg_vld       <= 1'b0;
            r_post_vs_prev <= 1'b0;
            r_armed        <= 1'b0;
        end else begin
            r_post_vs_prev <= r_vs_d[3];
            r_fg_vld       <= 1'b0;
            if (w_post_fall) begin
                r_armed <= 1'b1;
                if (r_armed) begin
                    r_fg_count <= r_acc;
                    r_fg_vld   <= 1'b1;
                end
                r_acc <= CNT_W'(w_hit);
            end else if (w_hit && (r_acc != '1)) begin
                r_acc <= r_acc + 1'b1;
            end
        end
    end

    assign fg_count     = r_fg_count;
    assign fg_count_vld = r_fg_vld;
`else
    assign fg_count     = '0;
    assign fg_count_vld = 1'b0;
`endif
endmodule

// File: tb/tb_ycbcr_skin_bin.sv
// Self-checking bench for ycbcr_skin_bin: arithmetic reference model compared
// every cycle, plus directed vectors with hand-computed values.
module tb_ycbcr_skin_bin;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        vs = 1'b0, hs = 1'b0, de = 1'b0;
    logic [15:0] pix = '0;
    logic        cfg_wr = 1'b0;
    logic [7:0]  c_crlo = 8'd135, c_crhi = 8'd160, c_cblo = 8'd115, c_cbhi = 8'd140;
    logic [1:0]  c_mode = 2'd0;

    logic        cfg_pending, cfg_pending4;
    logic [19:0] fg_count;
    logic [3:0]  fg_count4;
    logic        fg_vld, fg_vld4;

    ycbcr_skin_bin_if vif();
    ycbcr_skin_bin_if vif4();

    assign vif.pre_frame_vsync  = vs;
    assign vif.pre_frame_hsync  = hs;
    assign vif.pre_frame_de     = de;
    assign vif.pix_in           = pix;
    assign vif4.pre_frame_vsync = vs;
    assign vif4.pre_frame_hsync = hs;
    assign vif4.pre_frame_de    = de;
    assign vif4.pix_in          = pix;

    ycbcr_skin_bin #(.CR_LO_DEF(8'd135), .CR_HI_DEF(8'd160), .CB_LO_DEF(8'd115),
                     .CB_HI_DEF(8'd140), .CNT_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .vid(vif), .cfg_wr(cfg_wr),
        .cfg_cr_lo(c_crlo), .cfg_cr_hi(c_crhi), .cfg_cb_lo(c_cblo), .cfg_cb_hi(c_cbhi),
        .cfg_mode(c_mode), .cfg_pending(cfg_pending),
        .fg_count(fg_count), .fg_count_vld(fg_vld)
    );

    ycbcr_skin_bin #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .vid(vif4), .cfg_wr(cfg_wr),
        .cfg_cr_lo(c_crlo), .cfg_cr_hi(c_crhi), .cfg_cb_lo(c_cblo), .cfg_cb_hi(c_cbhi),
        .cfg_mode(c_mode), .cfg_pending(cfg_pending4),
        .fg_count(fg_count4), .fg_count_vld(fg_vld4)
    );

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: pixel + thresholds + mode -> {bin, pix_out}, straight from the colour formulas
    function automatic logic [16:0] model_out(input logic [15:0] p,
            input logic [7:0] crlo, input logic [7:0] crhi,
            input logic [7:0] cblo, input logic [7:0] cbhi, input logic [1:0] mode);
        int r, g, b, y, cb, cr;
        logic [7:0] yv;
        logic bin;
        logic [15:0] o;
        r = int'(p[15:11]); r = (r << 3) | (r >> 2);
        g = int'(p[10:5]);  g = (g << 2) | (g >> 4);
        b = int'(p[4:0]);   b = (b << 3) | (b >> 2);
        y  = ((77 * r + 150 * g + 29 * b) & 65535) >> 8;
        cb = ((128 * b - 43 * r - 85 * g + 32768) & 65535) >> 8;
        cr = ((128 * r - 107 * g - 21 * b + 32768) & 65535) >> 8;
        bin = (cr > int'(crlo)) && (cr < int'(crhi)) && (cb > int'(cblo)) && (cb < int'(cbhi));
        yv = y[7:0];
        case (mode)
            2'd0: o = p;
            2'd1: o = bin ? 16'hFFFF : 16'h0000;
            2'd2: o = {yv[7:3], yv[7:2], yv[7:3]};
            default: o = bin ? p : 16'h0000;
        endcase
        return {bin, o};
    endfunction

    logic [7:0]  m_crlo = 8'd135, m_crhi = 8'd160, m_cblo = 8'd115, m_cbhi = 8'd140;
    logic [7:0]  p_crlo = 8'd135, p_crhi = 8'd160, p_cblo = 8'd115, p_cbhi = 8'd140;
    logic [1:0]  m_mode = 2'd0, p_mode = 2'd0;
    logic        m_pending = 1'b0, m_vs_prev = 1'b0;
    logic [15:0] h_pix [4];
    logic        h_vs [4], h_hs [4], h_de [4];
    logic [15:0] e_pix = '0;
    logic        e_bin = 1'b0, e_vs = 1'b0, e_hs = 1'b0, e_de = 1'b0;
    int          warm = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_crlo = 8'd135; m_crhi = 8'd160; m_cblo = 8'd115; m_cbhi = 8'd140; m_mode = 2'd0;
            p_crlo = 8'd135; p_crhi = 8'd160; p_cblo = 8'd115; p_cbhi = 8'd140; p_mode = 2'd0;
            m_pending = 1'b0; m_vs_prev = 1'b0; warm = 0;
            for (int i = 0; i < 4; i++) begin
                h_pix[i] = '0; h_vs[i] = 1'b0; h_hs[i] = 1'b0; h_de[i] = 1'b0;
            end
        end else begin
            for (int i = 3; i > 0; i--) begin
                h_pix[i] = h_pix[i-1]; h_vs[i] = h_vs[i-1]; h_hs[i] = h_hs[i-1]; h_de[i] = h_de[i-1];
            end
            h_pix[0] = pix; h_vs[0] = vs; h_hs[0] = hs; h_de[0] = de;
            {e_bin, e_pix} = model_out(h_pix[3], m_crlo, m_crhi, m_cblo, m_cbhi, m_mode);
            e_vs = h_vs[3]; e_hs = h_hs[3]; e_de = h_de[3];
            if (vs && !m_vs_prev && cfg_wr) begin
                m_crlo = c_crlo; m_crhi = c_crhi; m_cblo = c_cblo; m_cbhi = c_cbhi; m_mode = c_mode;
                p_crlo = c_crlo; p_crhi = c_crhi; p_cblo = c_cblo; p_cbhi = c_cbhi; p_mode = c_mode;
                m_pending = 1'b0;
            end else if (vs && !m_vs_prev && m_pending) begin
                m_crlo = p_crlo; m_crhi = p_crhi; m_cblo = p_cblo; m_cbhi = p_cbhi; m_mode = p_mode;
                m_pending = 1'b0;
            end else if (cfg_wr) begin
                p_crlo = c_crlo; p_crhi = c_crhi; p_cblo = c_cblo; p_cbhi = c_cbhi; p_mode = c_mode;
                m_pending = 1'b1;
            end
            m_vs_prev = vs;
            if (warm < 4) warm++;
        end
    end

    always @(negedge clk) begin
        if (fg_vld) vld_cnt++;
        if (rst_n && warm >= 4) begin
            chk("cyc_pix_out", {16'd0, vif.pix_out}, {16'd0, e_pix});
            chk("cyc_bin_out", {31'd0, vif.bin_out}, {31'd0, e_bin});
            chk("cyc_vsync",   {31'd0, vif.post_frame_vsync}, {31'd0, e_vs});
            chk("cyc_hsync",   {31'd0, vif.post_frame_hsync}, {31'd0, e_hs});
            chk("cyc_de",      {31'd0, vif.post_frame_de}, {31'd0, e_de});
            chk("cyc_pending", {31'd0, cfg_pending}, {31'd0, m_pending});
        end
    end

    task automatic drive(input logic v, input logic h, input logic d, input logic [15:0] p);
        vs = v; hs = h; de = d; pix = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic vsync_pulse();
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic pipe_check(input string name, input logic [15:0] p,
                              input logic [15:0] exp_pix, input logic exp_bin);
        drive(1'b0, 1'b1, 1'b1, p);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 16'h0);
        chk({name, "_pix"}, {16'd0, vif.pix_out}, {16'd0, exp_pix});
        chk({name, "_bin"}, {31'd0, vif.bin_out}, {31'd0, exp_bin});
    endtask

    task automatic cfg_write(input logic [7:0] crlo, input logic [7:0] crhi,
                             input logic [7:0] cblo, input logic [7:0] cbhi, input logic [1:0] mode);
        c_crlo = crlo; c_crhi = crhi; c_cblo = cblo; c_cbhi = cbhi; c_mode = mode;
        cfg_wr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        cfg_wr = 1'b0;
    endtask

    task automatic apply(input logic [7:0] crlo, input logic [7:0] crhi,
                         input logic [7:0] cblo, input logic [7:0] cbhi, input logic [1:0] mode);
        cfg_write(crlo, crhi, cblo, cbhi, mode);
        chk("apply_pending_set", {31'd0, cfg_pending}, 32'd1);
        vsync_pulse();
        chk("apply_pending_clr", {31'd0, cfg_pending}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_pix_out", {16'd0, vif.pix_out}, 32'd0);
        chk("rst_bin_out", {31'd0, vif.bin_out}, 32'd0);
        chk("rst_post_de", {31'd0, vif.post_frame_de}, 32'd0);
        chk("rst_pending", {31'd0, cfg_pending}, 32'd0);
        chk("rst_fg_count", {12'd0, fg_count}, 32'd0);
        chk("rst_fg_vld", {31'd0, fg_vld}, 32'd0);
        rst_n = 1'b1;
        vsync_pulse();

        pipe_check("m0_white", 16'hFFFF, 16'hFFFF, 1'b0);
        pipe_check("m0_skin",  16'hFE5B, 16'hFE5B, 1'b1);
        apply(8'd135, 8'd160, 8'd115, 8'd140, 2'd1);
        pipe_check("m1_skin",  16'hFE5B, 16'hFFFF, 1'b1);
        pipe_check("m1_white", 16'hFFFF, 16'h0000, 1'b0);
        apply(8'd135, 8'd160, 8'd115, 8'd140, 2'd2);
        pipe_check("m2_skin",  16'hFE5B, 16'hDEFB, 1'b1);
        pipe_check("m2_white", 16'hFFFF, 16'hFFFF, 1'b0);
        apply(8'd135, 8'd160, 8'd115, 8'd140, 2'd3);
        pipe_check("m3_skin",  16'hFE5B, 16'hFE5B, 1'b1);
        pipe_check("m3_white", 16'hFFFF, 16'h0000, 1'b0);

        cfg_write(8'd155, 8'd160, 8'd115, 8'd140, 2'd3);
        chk("mid_pending", {31'd0, cfg_pending}, 32'd1);
        pipe_check("mid_still_old", 16'hFE5B, 16'hFE5B, 1'b1);
        vsync_pulse();
        chk("mid_applied_pending", {31'd0, cfg_pending}, 32'd0);
        pipe_check("mid_new_cfg", 16'hFE5B, 16'h0000, 1'b0);

        cfg_write(8'd200, 8'd250, 8'd115, 8'd140, 2'd0);
        cfg_write(8'd135, 8'd160, 8'd115, 8'd140, 2'd1);
        vsync_pulse();
        pipe_check("overwrite", 16'hFE5B, 16'hFFFF, 1'b1);

        c_crlo = 8'd135; c_crhi = 8'd160; c_cblo = 8'd115; c_cbhi = 8'd140; c_mode = 2'd2;
        cfg_wr = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        cfg_wr = 1'b0;
        chk("rise_wr_pending", {31'd0, cfg_pending}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        pipe_check("rise_wr_skin", 16'hFE5B, 16'hDEFB, 1'b1);

        apply(8'd152, 8'd160, 8'd115, 8'd140, 2'd1);
        pipe_check("cr_lo_eq", 16'hFE5B, 16'h0000, 1'b0);
        apply(8'd151, 8'd160, 8'd115, 8'd140, 2'd1);
        pipe_check("cr_lo_below", 16'hFE5B, 16'hFFFF, 1'b1);
        apply(8'd135, 8'd152, 8'd115, 8'd140, 2'd1);
        pipe_check("cr_hi_eq", 16'hFE5B, 16'h0000, 1'b0);
        apply(8'd135, 8'd160, 8'd128, 8'd140, 2'd1);
        pipe_check("cb_lo_eq", 16'hFE5B, 16'h0000, 1'b0);
        apply(8'd135, 8'd160, 8'd115, 8'd128, 2'd1);
        pipe_check("cb_hi_eq", 16'hFE5B, 16'h0000, 1'b0);
        apply(8'd160, 8'd150, 8'd115, 8'd140, 2'd1);
        pipe_check("cr_inverted", 16'hFE5B, 16'h0000, 1'b0);
        apply(8'd135, 8'd160, 8'd140, 8'd115, 2'd1);
        pipe_check("cb_inverted", 16'hFE5B, 16'h0000, 1'b0);
        apply(8'd135, 8'd160, 8'd115, 8'd140, 2'd0);

        vsync_pulse();
        for (int i = 0; i < 100; i++)
            drive(1'b0, 1'b1, 1'b1, (i < 74 && (i % 2) == 0) ? 16'hFE5B : 16'hFFFF);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 16'h0);
        vsync_pulse();
`ifdef YCBCR_FG_COUNT_EN
        n = 0;
        while (!fg_vld && n < 20) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0);
            n++;
        end
        chk("fg_vld_seen", {31'd0, fg_vld}, 32'd1);
        chk("fg_vld4_seen", {31'd0, fg_vld4}, 32'd1);
        chk("fg_count_37", {12'd0, fg_count}, 32'd37);
        chk("fg_count_sat", {28'd0, fg_count4}, 32'd15);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        chk("fg_vld_one_cycle", {31'd0, fg_vld}, 32'd0);
`else
        n = 0;
        repeat (10) drive(1'b0, 1'b0, 1'b0, 16'h0);
        chk("fg_count_off", {12'd0, fg_count}, 32'd0);
        chk("fg_vld_off", {31'd0, fg_vld}, 32'd0);
`endif

        apply(8'd155, 8'd160, 8'd115, 8'd140, 2'd1);
        cfg_write(8'd100, 8'd200, 8'd100, 8'd200, 2'd2);
        repeat (5) drive(1'b0, 1'b1, 1'b1, 16'hFE5B);
        vs = 1'b0; hs = 1'b1; de = 1'b1; pix = 16'hFE5B;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pix_out", {16'd0, vif.pix_out}, 32'd0);
        chk("arst_bin_out", {31'd0, vif.bin_out}, 32'd0);
        chk("arst_post_de", {31'd0, vif.post_frame_de}, 32'd0);
        chk("arst_post_hs", {31'd0, vif.post_frame_hsync}, 32'd0);
        chk("arst_pending", {31'd0, cfg_pending}, 32'd0);
        chk("arst_fg_count", {12'd0, fg_count}, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        rst_n = 1'b1;
        n = vld_cnt;
        vsync_pulse();
        repeat (10) drive(1'b0, 1'b0, 1'b0, 16'h0);
        chk("arst_no_vld", n, vld_cnt);
        pipe_check("arst_defaults", 16'hFE5B, 16'hFE5B, 1'b1);
`ifndef YCBCR_FG_COUNT_EN
        chk("no_vld_ever", vld_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
